// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, the
// "no interrupt" ID and the request FSM encoding.
package int_ctrl_pkg;

    localparam logic [4:0] INT_CTRL_ENABLE    = 5'h00;
    localparam logic [4:0] INT_CTRL_TYPE      = 5'h04;
    localparam logic [4:0] INT_CTRL_PENDING   = 5'h08;
    localparam logic [4:0] INT_CTRL_PRIO0     = 5'h0C;
    localparam logic [4:0] INT_CTRL_PRIO1     = 5'h10;
    localparam logic [4:0] INT_CTRL_CLAIM     = 5'h14;
    localparam logic [4:0] INT_CTRL_COMPLETE  = 5'h18;
    localparam logic [4:0] INT_CTRL_THRESHOLD = 5'h1C;

    localparam logic [7:0] INT_ID_NONE = 8'hFF;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/int_ctrl_arb.sv
// Combinational priority picker: highest priority among candidates wins,
// equal priorities resolve to the lowest source index.
module int_ctrl_arb
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 32,
    parameter int PRIO_W  = 2
) (
    input  logic [NUM_SRC-1:0]             cand,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    output logic                           valid,
    output logic [7:0]                     id,
    output logic [PRIO_W-1:0]              top_prio
);

    // Scanning downward with >= lets a lower index take over on a tie.
    always_comb begin
        valid    = 1'b0;
        id       = INT_ID_NONE;
        top_prio = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i] && (!valid || prio[i] >= top_prio)) begin
                valid    = 1'b1;
                id       = 8'(i);
                top_prio = prio[i];
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller feeding the core's int_req/int_id port.
// Define INT_CTRL_SYNC_EN to add a 2-flop synchronizer on every source line.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 32,
    parameter int PRIO_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic               int_req_o,
    output logic [7:0]         int_id_o
);

    logic [NUM_SRC-1:0]             src_s, src_prev_q;
    logic [NUM_SRC-1:0]             enable_q, type_q, pend_q, insvc_q;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
    logic [PRIO_W-1:0]              thr_q;
    state_t                         state_q, state_d;
    logic [7:0]                     id_q, id_d;

    logic [4:0]  off;
    logic        wr_en, rd_en, claim_hit;
    logic [NUM_SRC-1:0] cand, claim_mask, cmpl_mask, clr_mask;
    logic        lat_cand;
    logic [PRIO_W-1:0] lat_prio, win_prio;
    logic        win_valid;
    logic [7:0]  win_id;
    logic [31:0] prio0_rd, prio1_rd, rd_data;
    logic        unused_ok;

`ifdef INT_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end
    assign src_s = sync2_q;
`else
    assign src_s = src_i;
`endif

    assign off       = {addr_i[4:2], 2'b00};
    assign wr_en     = req_i & we_i;
    assign rd_en     = req_i & ~we_i;
    assign claim_hit = rd_en && (off == INT_CTRL_CLAIM);
    assign unused_ok = ^{addr_i[31:5], addr_i[1:0]};

    always_comb begin
        cand       = '0;
        claim_mask = '0;
        cmpl_mask  = '0;
        lat_cand   = 1'b0;
        lat_prio   = '0;
        clr_mask   = (wr_en && off == INT_CTRL_PENDING) ? data_i[NUM_SRC-1:0] : '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i]       = pend_q[i] & enable_q[i] & ~insvc_q[i] & (prio_q[i] > thr_q);
            claim_mask[i] = claim_hit && win_valid && (win_id == 8'(i));
            cmpl_mask[i]  = wr_en && (off == INT_CTRL_COMPLETE) && (data_i[7:0] == 8'(i));
            if (id_q == 8'(i)) begin
                lat_cand = cand[i];
                lat_prio = prio_q[i];
            end
        end
    end

    int_ctrl_arb #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) u_arb (
        .cand     (cand),
        .prio     (prio_q),
        .valid    (win_valid),
        .id       (win_id),
        .top_prio (win_prio)
    );

    // Configuration registers. PRIO0/PRIO1 each pack 16 sources, so PRIO_W <= 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
            type_q   <= '0;
            prio_q   <= '0;
            thr_q    <= '0;
        end else if (wr_en) begin
            if (off == INT_CTRL_ENABLE)    enable_q <= data_i[NUM_SRC-1:0];
            if (off == INT_CTRL_TYPE)      type_q   <= data_i[NUM_SRC-1:0];
            if (off == INT_CTRL_THRESHOLD) thr_q    <= data_i[PRIO_W-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (i < 16) begin
                    if (off == INT_CTRL_PRIO0) prio_q[i] <= data_i[i*PRIO_W +: PRIO_W];
                end else begin
                    if (off == INT_CTRL_PRIO1) prio_q[i] <= data_i[(i-16)*PRIO_W +: PRIO_W];
                end
            end
        end
    end

    // Edge sources: clears first, then a fresh rising edge re-sets the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q <= '0;
            pend_q     <= '0;
            insvc_q    <= '0;
        end else begin
            src_prev_q <= src_s;
            pend_q     <= (type_q & ((pend_q & ~clr_mask & ~claim_mask) | (src_s & ~src_prev_q)))
                        | (~type_q & src_s);
            insvc_q    <= (insvc_q & ~cmpl_mask) | claim_mask;
        end
    end

    always_comb begin
        prio0_rd = '0;
        prio1_rd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i < 16) prio0_rd[i*PRIO_W +: PRIO_W] = prio_q[i];
            else        prio1_rd[(i-16)*PRIO_W +: PRIO_W] = prio_q[i];
        end
        case (off)
            INT_CTRL_ENABLE:    rd_data = 32'(enable_q);
            INT_CTRL_TYPE:      rd_data = 32'(type_q);
            INT_CTRL_PENDING:   rd_data = 32'(pend_q);
            INT_CTRL_PRIO0:     rd_data = prio0_rd;
            INT_CTRL_PRIO1:     rd_data = prio1_rd;
            INT_CTRL_CLAIM:     rd_data = 32'(win_valid ? win_id : INT_ID_NONE);
            INT_CTRL_THRESHOLD: rd_data = 32'(thr_q);
            default:            rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_o <= '0;
        else if (rd_en) data_o <= rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // A claim in IDLE suppresses the launch so the claimed ID never flashes.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid && !claim_hit) begin
                    state_d = S_REQ;
                    id_d    = win_id;
                end
            end
            S_REQ: begin
                if (claim_hit || !lat_cand)  state_d = S_IDLE;
                else if (win_prio > lat_prio) id_d   = win_id;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign int_req_o = (state_q == S_REQ);
    assign int_id_o  = id_q;

endmodule
